// File: rtl/updn_counter.sv
`default_nettype none
// ============================================================================
// updn_counter : up/down counter with sync load, runtime terminal value and
//                wrap/saturate boundaries. Optional macro UPDN_COUNTER_PRESCALE_EN
//                adds a PRESCALE enable divider.                 Rev 1.0
// ============================================================================
module updn_counter #(
    parameter int CNT_WIDTH = 4,
    parameter int SAT_MODE  = 0
`ifdef UPDN_COUNTER_PRESCALE_EN
    ,
    parameter int PRESCALE  = 4
`endif
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 up,
    input  logic                 ld,
    input  logic [CNT_WIDTH-1:0] ld_val,
    input  logic [CNT_WIDTH-1:0] max_val,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 tc,
    output logic                 ovf
);

    localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_tc;
    logic                 r_ovf;

    logic                 w_step;
    logic                 w_bnd;
    logic [CNT_WIDTH-1:0] w_next;
    logic [CNT_WIDTH-1:0] w_ld_clamped;

`ifdef UPDN_COUNTER_PRESCALE_EN
    localparam int                c_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PS_W-1:0] c_ps_last = c_PS_W'(PRESCALE - 1);
    localparam logic [c_PS_W-1:0] c_ps_one  = c_PS_W'(1);

    logic [c_PS_W-1:0] r_ps;

    assign w_step = en && (r_ps == c_ps_last);

    // Phase only advances on enabled cycles, so dropping en freezes it.
    always_ff @(posedge clk) begin
        if (clr || ld) begin
            r_ps <= '0;
        end else if (en) begin
            r_ps <= w_step ? '0 : (r_ps + c_ps_one);
        end
    end
`else
    assign w_step = en;
`endif

    assign w_ld_clamped = (ld_val > max_val) ? max_val : ld_val;

    always_comb begin
        w_next = r_count;
        w_bnd  = 1'b0;
        if (up) begin
            // >= also catches a count stranded above a freshly lowered max_val
            if (r_count >= max_val) begin
                w_bnd  = 1'b1;
                w_next = (SAT_MODE != 0) ? max_val : '0;
            end else begin
                w_next = r_count + c_one;
            end
        end else begin
            if (r_count == '0) begin
                w_bnd  = 1'b1;
                w_next = (SAT_MODE != 0) ? '0 : max_val;
            end else begin
                w_next = r_count - c_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (ld) begin
            r_count <= w_ld_clamped;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_step) begin
            r_count <= w_next;
            r_tc    <= w_bnd;
            r_ovf   <= r_ovf | w_bnd;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_updn_counter.sv
`default_nettype none
// ============================================================================
// tb_updn_counter : checks a wrapping and a saturating updn_counter side by
//                   side against a reference model.                Rev 1.0
// ============================================================================
module tb_updn_counter;

    localparam int W = 4;
`ifdef UPDN_COUNTER_PRESCALE_EN
    localparam int PS = 3;
`else
    localparam int PS = 1;
`endif

    logic         clk = 1'b0;
    logic         clr, en, up, ld;
    logic [W-1:0] ld_val, max_val;
    logic [W-1:0] count0, count1;
    logic         tc0, tc1, ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    int m_cnt[2];
    int m_tc[2];
    int m_ovf[2];
    int m_ph[2];

    always #5 clk = ~clk;

    updn_counter #(
        .CNT_WIDTH(W),
        .SAT_MODE(0)
`ifdef UPDN_COUNTER_PRESCALE_EN
        , .PRESCALE(PS)
`endif
    ) u0 (
        .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld),
        .ld_val(ld_val), .max_val(max_val),
        .count(count0), .tc(tc0), .ovf(ovf0)
    );

    updn_counter #(
        .CNT_WIDTH(W),
        .SAT_MODE(1)
`ifdef UPDN_COUNTER_PRESCALE_EN
        , .PRESCALE(PS)
`endif
    ) u1 (
        .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld),
        .ld_val(ld_val), .max_val(max_val),
        .count(count1), .tc(tc1), .ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one counter instance; s selects saturate mode.
    function automatic void model_step(input int s);
        int mx;
        mx = int'(max_val);
        if (clr) begin
            m_cnt[s] = 0; m_tc[s] = 0; m_ovf[s] = 0; m_ph[s] = 0;
        end else if (ld) begin
            m_cnt[s] = (int'(ld_val) < mx) ? int'(ld_val) : mx;
            m_tc[s] = 0; m_ovf[s] = 0; m_ph[s] = 0;
        end else if (en && (m_ph[s] + 1 < PS)) begin
            m_ph[s]++;
            m_tc[s] = 0;
        end else if (en) begin
            m_ph[s] = 0;
            if (up && m_cnt[s] < mx) begin
                m_cnt[s]++; m_tc[s] = 0;
            end else if (!up && m_cnt[s] > 0) begin
                m_cnt[s]--; m_tc[s] = 0;
            end else begin
                if (up) m_cnt[s] = (s == 1) ? mx : 0;
                else    m_cnt[s] = (s == 1) ? 0 : mx;
                m_tc[s] = 1; m_ovf[s] = 1;
            end
        end else begin
            m_tc[s] = 0;
        end
    endfunction

    task automatic drive(input logic c, input logic l, input logic e, input logic u,
                         input int lv, input int mv);
        clr = c; ld = l; en = e; up = u;
        ld_val = W'(lv); max_val = W'(mv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
        chk("wrap.count", {28'b0, count0}, m_cnt[0]);
        chk("wrap.tc",    {31'b0, tc0},    m_tc[0]);
        chk("wrap.ovf",   {31'b0, ovf0},   m_ovf[0]);
        chk("sat.count",  {28'b0, count1}, m_cnt[1]);
        chk("sat.tc",     {31'b0, tc1},    m_tc[1]);
        chk("sat.ovf",    {31'b0, ovf1},   m_ovf[1]);
    endtask

    initial begin
        foreach (m_cnt[i]) begin
            m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_ph[i] = 0;
        end
        drive(1, 0, 0, 0, 0, 15);
        tick();
        tick();
        chk("reset.count", {28'b0, count0}, 0);
        chk("reset.tc",    {31'b0, tc0},    0);
        chk("reset.ovf",   {31'b0, ovf0},   0);

`ifndef UPDN_COUNTER_PRESCALE_EN
        // Free run through the top wrap
        for (int k = 1; k <= 17; k++) begin
            drive(0, 0, 1, 1, 0, 15);
            tick();
            chk("freerun.count", {28'b0, count0}, k % 16);
            chk("freerun.tc",    {31'b0, tc0},    (k == 16) ? 1 : 0);
            chk("freerun.ovf",   {31'b0, ovf0},   (k >= 16) ? 1 : 0);
        end

        // Down-wrap to max_val=9
        begin
            int e2[4] = '{1, 0, 9, 8};
            drive(0, 1, 0, 0, 2, 9);
            tick();
            chk("dnwrap.load", {28'b0, count0}, 2);
            for (int k = 0; k < 4; k++) begin
                drive(0, 0, 1, 0, 2, 9);
                tick();
                chk("dnwrap.count", {28'b0, count0}, e2[k]);
                chk("dnwrap.tc",    {31'b0, tc0},    (k == 2) ? 1 : 0);
            end
            chk("dnwrap.ovf", {31'b0, ovf0}, 1);
        end

        // Saturation at max_val=5 and at zero
        begin
            int e3u[4] = '{4, 5, 5, 5};
            int e3d[7] = '{4, 3, 2, 1, 0, 0, 0};
            drive(0, 1, 0, 0, 3, 5);
            tick();
            chk("sat.load", {28'b0, count1}, 3);
            for (int k = 0; k < 4; k++) begin
                drive(0, 0, 1, 1, 3, 5);
                tick();
                chk("sat.up.count", {28'b0, count1}, e3u[k]);
                chk("sat.up.tc",    {31'b0, tc1},    (k >= 2) ? 1 : 0);
            end
            for (int k = 0; k < 7; k++) begin
                drive(0, 0, 1, 0, 3, 5);
                tick();
                chk("sat.dn.count", {28'b0, count1}, e3d[k]);
                chk("sat.dn.tc",    {31'b0, tc1},    (k >= 5) ? 1 : 0);
            end
        end

        // Load clamp beats enable; clear beats load
        drive(0, 1, 1, 1, 12, 7);
        tick();
        chk("ldclamp.count", {28'b0, count0}, 7);
        chk("ldclamp.tc",    {31'b0, tc0},    0);
        chk("ldclamp.ovf",   {31'b0, ovf0},   0);
        chk("ldclamp.sat",   {28'b0, count1}, 7);
        drive(1, 1, 1, 1, 12, 7);
        tick();
        chk("clrld.count", {28'b0, count0}, 0);

        // max_val=0: every enabled step is a boundary
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1, (k < 2) ? 1'b1 : 1'b0, 0, 0);
            tick();
            chk("max0.count", {28'b0, count0}, 0);
            chk("max0.tc",    {31'b0, tc0},    1);
            chk("max0.sattc", {31'b0, tc1},    1);
        end
`else
        // Prescale by 3 with a two-cycle enable gap mid-sequence
        begin
            int e6[11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};
            for (int k = 0; k < 11; k++) begin
                drive(0, 0, (k == 4 || k == 5) ? 1'b0 : 1'b1, 1, 0, 15);
                tick();
                chk("prescale.count", {28'b0, count0}, e6[k]);
            end
        end
`endif

        // Randomised traffic with sporadic clears
        begin
            int mv;
            logic c;
            mv = 15;
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(0, 15) == 0) mv = int'($urandom_range(0, 15));
                c = ($urandom_range(0, 9) == 0);
                drive(c, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), mv);
                tick();
                if (c) begin
                    chk("rndclr.count", {28'b0, count0}, 0);
                    chk("rndclr.tc",    {31'b0, tc1},    0);
                    chk("rndclr.ovf",   {31'b0, ovf0},   0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
